// File: rtl/rram_sa_vote.sv
// Multi-read sense-amp sequencer with per-bit majority vote and stability mask.
// Each read is SETUP (s+1) -> CLK (1) -> WAIT (until sa_rdy or timeout), with a
// one-cycle REARM between reads. Per-bit one-counters live in one small
// sub-module per data bit so the vote/stable logic stays local to each bit.

module rram_sa_vote_bit #(
    parameter int CW = 4
) (
    input  logic          i_mclk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_acc,
    input  logic          i_bit,
    input  logic [CW-1:0] i_n,
    output logic          o_vote,
    output logic          o_stable
);
    logic [CW-1:0] r_ones;
    logic [CW-1:0] w_ones_nxt;
    logic          w_inc;

    // Vote and stability are taken on the post-update count so the final read
    // is included in the result registered on the DONE transition.
    assign w_inc      = i_acc & i_bit;
    assign w_ones_nxt = r_ones + CW'(w_inc);
    assign o_vote     = {w_ones_nxt, 1'b0} > {1'b0, i_n};
    assign o_stable   = (w_ones_nxt == '0) || (w_ones_nxt == i_n);

    // One-counter: cleared on reset or when a new operation is accepted.
    always_ff @(posedge i_mclk) begin
        if (i_rst || i_clr) r_ones <= '0;
        else                r_ones <= w_ones_nxt;
    end
endmodule

module rram_sa_vote #(
    parameter  int WORD_SIZE      = 48,
    parameter  int NUM_READS_MAX  = 15,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int CW             = $clog2(NUM_READS_MAX + 1)
) (
    input  logic                 i_mclk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CW-1:0]        i_num_reads,
    input  logic [7:0]           i_setup_cycles,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic                 o_sa_en,
    output logic                 o_sa_clk,
    input  logic [WORD_SIZE-1:0] i_sa_do,
    input  logic                 i_sa_rdy,
    output logic [WORD_SIZE-1:0] o_rd_data,
    output logic [WORD_SIZE-1:0] o_rd_stable
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CLK, S_WAIT, S_REARM, S_DONE
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CW-1:0]        r_n;
    logic [7:0]           r_s;
    logic [7:0]           r_setup_cnt;
    logic [CW-1:0]        r_idx;
    logic [TW-1:0]        r_wait_cnt;
    logic [CW-1:0]        w_n_clamp;
    logic                 w_start_acc;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_abort;
    logic                 w_busy_nxt;
    logic                 w_en_nxt;
    logic                 w_clk_nxt;
    logic                 w_done_nxt;
    logic [WORD_SIZE-1:0] w_vote;
    logic [WORD_SIZE-1:0] w_stable;

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_accept    = (r_state == S_WAIT) && i_sa_rdy;
    assign w_last      = (r_idx + CW'(1)) == r_n;
    // A late sa_rdy in the last allowed WAIT cycle beats the timeout.
    assign w_abort     = (r_state == S_WAIT) && !i_sa_rdy &&
                         (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Read count: 0 means one read, anything above the maximum is clamped.
    always_comb begin
        w_n_clamp = i_num_reads;
        if (i_num_reads == '0)                       w_n_clamp = CW'(1);
        else if (int'(i_num_reads) > NUM_READS_MAX)  w_n_clamp = CW'(NUM_READS_MAX);
    end

    // Per-bit one-counters with their vote and stability decisions.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_SIZE; gi++) begin : g_bit
            rram_sa_vote_bit #(.CW(CW)) u_bit (
                .i_mclk   (i_mclk),
                .i_rst    (i_rst),
                .i_clr    (w_start_acc),
                .i_acc    (w_accept),
                .i_bit    (i_sa_do[gi]),
                .i_n      (r_n),
                .o_vote   (w_vote[gi]),
                .o_stable (w_stable[gi])
            );
        end
    endgenerate

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_SETUP;
            S_SETUP: if (r_setup_cnt == r_s) w_state_nxt = S_CLK;
            S_CLK:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_accept)     w_state_nxt = w_last ? S_DONE : S_REARM;
                else if (w_abort) w_state_nxt = S_DONE;
            end
            S_REARM: w_state_nxt = S_SETUP;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state; the results are registered below so
    // every pin changes cleanly on the clock edge.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_en_nxt   = (w_state_nxt == S_SETUP) || (w_state_nxt == S_CLK) ||
                     (w_state_nxt == S_WAIT);
        w_clk_nxt  = (w_state_nxt == S_CLK);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // State, counters and latched config.
    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_s         <= '0;
            r_idx       <= '0;
            r_setup_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_setup_cnt <= (r_state == S_SETUP) ? r_setup_cnt + 8'd1 : 8'd0;
            r_wait_cnt  <= (r_state == S_WAIT) ? r_wait_cnt + TW'(1) : '0;
            if (w_start_acc) begin
                r_n   <= w_n_clamp;
                r_s   <= i_setup_cycles;
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + CW'(1);
            end
        end
    end

    // Registered outputs; results load only when entering DONE and hold after.
    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_sa_en     <= 1'b0;
            o_sa_clk    <= 1'b0;
            o_rd_data   <= '0;
            o_rd_stable <= '0;
        end else begin
            o_busy    <= w_busy_nxt;
            o_done    <= w_done_nxt;
            o_timeout <= w_abort;
            o_sa_en   <= w_en_nxt;
            o_sa_clk  <= w_clk_nxt;
            if (r_state == S_WAIT && w_state_nxt == S_DONE) begin
                o_rd_data   <= w_abort ? '0 : w_vote;
                o_rd_stable <= w_abort ? '0 : w_stable;
            end
        end
    end
endmodule

// File: tb/tb_rram_sa_vote.sv
// Bench for rram_sa_vote. Operations are planned up front from the timing
// rules: each plan fills per-cycle expected outputs and per-cycle stimulus.
// A second, small instance (NUM_READS_MAX=5) covers the clamp path.

module tb_rram_sa_vote;
    localparam int MAXC = 12000;

    logic        clk = 1'b0;
    logic        rst, start, sa_rdy;
    logic [3:0]  num_reads;
    logic [7:0]  setup;
    logic [47:0] sa_do, rd_data, rd_stable;
    logic        busy, done, timeout, sa_en, sa_clk;

    logic        rst_s, start_s, sa_rdy_s;
    logic [2:0]  num_reads_s;
    logic [7:0]  setup_s;
    logic [47:0] sa_do_s, rd_data_s, rd_stable_s;
    logic        busy_s, done_s, timeout_s, sa_en_s, sa_clk_s;

    rram_sa_vote u_dut (
        .i_mclk(clk), .i_rst(rst), .i_start(start), .i_num_reads(num_reads),
        .i_setup_cycles(setup), .o_busy(busy), .o_done(done), .o_timeout(timeout),
        .o_sa_en(sa_en), .o_sa_clk(sa_clk), .i_sa_do(sa_do), .i_sa_rdy(sa_rdy),
        .o_rd_data(rd_data), .o_rd_stable(rd_stable)
    );

    rram_sa_vote #(.NUM_READS_MAX(5)) u_small (
        .i_mclk(clk), .i_rst(rst_s), .i_start(start_s), .i_num_reads(num_reads_s),
        .i_setup_cycles(setup_s), .o_busy(busy_s), .o_done(done_s),
        .o_timeout(timeout_s), .o_sa_en(sa_en_s), .o_sa_clk(sa_clk_s),
        .i_sa_do(sa_do_s), .i_sa_rdy(sa_rdy_s), .o_rd_data(rd_data_s),
        .o_rd_stable(rd_stable_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected outputs per cycle
    bit          e_busy[MAXC], e_en[MAXC], e_clk[MAXC], e_done[MAXC], e_to[MAXC];
    logic [47:0] e_data[MAXC], e_stab[MAXC];
    // stimulus per cycle
    bit          p_start[MAXC], p_rdy[MAXC], p_rst[MAXC];
    logic [47:0] p_do[MAXC];
    logic [3:0]  p_nr[MAXC];
    logic [7:0]  p_s[MAXC];

    int          g_w[15];
    logic [47:0] g_d[15];

    typedef struct {
        int t; bit done; bit to;
        logic [47:0] dm, dv, sm, sv;
    } pin_t;
    pin_t pins[$];

    int tests = 0, fails = 0, end_c = 0;
    bit small_fin = 1'b0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return x[47:0];
    endfunction

    task automatic hold_from(input int t, input logic [47:0] d, input logic [47:0] s);
        for (int i = t; i < MAXC; i++) begin
            e_data[i] = d;
            e_stab[i] = s;
        end
    endtask

    task automatic add_pin(input int t, input bit dn, input bit to, input logic [47:0] dm,
                           input logic [47:0] dv, input logic [47:0] sm, input logic [47:0] sv);
        pin_t p;
        p.t = t; p.done = dn; p.to = to; p.dm = dm; p.dv = dv; p.sm = sm; p.sv = sv;
        pins.push_back(p);
    endtask

    // Plan one operation whose start is driven in cycle P. g_w[k] is the WAIT
    // cycle (1-based) in which read k returns data; 0 means it never returns.
    task automatic plan_op(input int P, input int nr, input int s, output int D,
                           output int wait2);
        int n, t, ones[48];
        bit ab;
        logic [47:0] d, st;
        n = (nr == 0) ? 1 : ((nr > 15) ? 15 : nr);
        p_start[P] = 1'b1; p_nr[P] = nr[3:0]; p_s[P] = s[7:0];
        foreach (ones[b]) ones[b] = 0;
        t = P + 1; ab = 1'b0; wait2 = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j <= s; j++) begin e_busy[t] = 1; e_en[t] = 1; t++; end
            e_busy[t] = 1; e_en[t] = 1; e_clk[t] = 1; t++;
            if (k == 1) wait2 = t;
            if (g_w[k] == 0) begin
                for (int j = 0; j < 255; j++) begin
                    e_busy[t] = 1; e_en[t] = 1; p_rdy[t] = 0; t++;
                end
                ab = 1'b1;
                break;
            end
            for (int j = 1; j <= g_w[k]; j++) begin
                e_busy[t] = 1; e_en[t] = 1;
                p_rdy[t] = (j == g_w[k]);
                if (j == g_w[k]) p_do[t] = g_d[k];
                t++;
            end
            for (int b = 0; b < 48; b++) ones[b] += int'(g_d[k][b]);
            if (k < n - 1) begin e_busy[t] = 1; t++; end
        end
        e_busy[t] = 1; e_done[t] = 1; e_to[t] = ab;
        if (ab) hold_from(t, '0, '0);
        else begin
            for (int b = 0; b < 48; b++) begin
                d[b]  = (2 * ones[b] > n);
                st[b] = (ones[b] == 0) || (ones[b] == n);
            end
            hold_from(t, d, st);
        end
        for (int c = P + 1; c <= t; c++) p_start[c] = ($urandom_range(0, 7) == 0);
        D = t;
    endtask

    // Reset driven during cycle X: everything reads 0 from X+1, no done.
    task automatic plan_reset(input int X, input int D);
        p_rst[X] = 1'b1;
        for (int c = X; c <= D; c++) p_start[c] = 1'b0;
        for (int c = X + 1; c <= D; c++) begin
            e_busy[c] = 0; e_en[c] = 0; e_clk[c] = 0; e_done[c] = 0; e_to[c] = 0;
        end
        hold_from(X + 1, '0, '0);
    endtask

    // Per-cycle comparison against the plan, plus literal pins.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= end_c) begin
            chk("busy",      48'(busy),    48'(e_busy[cyc]));
            chk("done",      48'(done),    48'(e_done[cyc]));
            chk("timeout",   48'(timeout), 48'(e_to[cyc]));
            chk("sa_en",     48'(sa_en),   48'(e_en[cyc]));
            chk("sa_clk",    48'(sa_clk),  48'(e_clk[cyc]));
            chk("rd_data",   rd_data,      e_data[cyc]);
            chk("rd_stable", rd_stable,    e_stab[cyc]);
            foreach (pins[i]) begin
                if (pins[i].t == cyc) begin
                    chk("pin_done",       48'(done),    48'(pins[i].done));
                    chk("pin_timeout",    48'(timeout), 48'(pins[i].to));
                    chk("pin_model_done", 48'(e_done[cyc]), 48'(pins[i].done));
                    if (pins[i].dm != '0) begin
                        chk("pin_data",       rd_data & pins[i].dm,     pins[i].dv);
                        chk("pin_model_data", e_data[cyc] & pins[i].dm, pins[i].dv);
                    end
                    if (pins[i].sm != '0) begin
                        chk("pin_stable",       rd_stable & pins[i].sm,   pins[i].sv);
                        chk("pin_model_stable", e_stab[cyc] & pins[i].sm, pins[i].sv);
                    end
                end
            end
        end
    end

    task automatic apply(input int c);
        rst = p_rst[c]; start = p_start[c]; num_reads = p_nr[c]; setup = p_s[c];
        sa_rdy = p_rdy[c]; sa_do = p_do[c];
    endtask

    initial begin
        int P, D, w2, X, r;
        logic [47:0] ones48;
        ones48 = '1;
        for (int c = 0; c < MAXC; c++) begin
            p_rdy[c] = ($urandom_range(0, 3) == 0); p_do[c] = rnd48();
            p_nr[c] = 4'($urandom_range(0, 15)); p_s[c] = 8'($urandom_range(0, 255));
            p_start[c] = 0; p_rst[c] = 0;
            e_busy[c] = 0; e_en[c] = 0; e_clk[c] = 0; e_done[c] = 0; e_to[c] = 0;
            e_data[c] = '0; e_stab[c] = '0;
        end
        for (int c = 0; c < 3; c++) p_rst[c] = 1;

        // single read
        P = 5; g_w[0] = 1; g_d[0] = 48'hA5A5_0000_FFFF;
        plan_op(P, 1, 0, D, w2);
        add_pin(P + 4, 1, 0, ones48, 48'hA5A5_0000_FFFF, ones48, ones48);
        // majority vote, back to back with the previous done
        P = D + 1;
        g_w[0] = 1; g_w[1] = 1; g_w[2] = 1;
        g_d[0] = 48'hF0; g_d[1] = 48'hCC; g_d[2] = 48'hAA;
        plan_op(P, 3, 2, D, w2);
        add_pin(P + 18, 1, 0, 48'hFF, 48'hE8, 48'hFF, 48'h81);
        // tie
        P = D + 3; g_w[0] = 2; g_w[1] = 3; g_d[0] = 48'h1; g_d[1] = 48'h0;
        plan_op(P, 2, 1, D, w2);
        add_pin(D, 1, 0, 48'h1, 48'h0, 48'h1, 48'h0);
        // timeout
        P = D + 2; g_w[0] = 0;
        plan_op(P, 2, 0, D, w2);
        add_pin(P + 258, 1, 1, ones48, '0, ones48, '0);
        // ready in the last allowed WAIT cycle
        P = D + 2; g_w[0] = 255; g_d[0] = 48'h1234_5678_9ABC;
        plan_op(P, 1, 0, D, w2);
        add_pin(P + 258, 1, 0, ones48, 48'h1234_5678_9ABC, '0, '0);
        // zero read count behaves as one read
        P = D + 2; g_w[0] = 1; g_d[0] = ones48;
        plan_op(P, 0, 0, D, w2);
        add_pin(P + 4, 1, 0, ones48, ones48, ones48, ones48);
        // reset in WAIT of read 2
        P = D + 2;
        for (int k = 0; k < 3; k++) begin g_w[k] = 2; g_d[k] = rnd48(); end
        plan_op(P, 3, 1, D, w2);
        X = w2 + 1;
        plan_reset(X, D);
        add_pin(X + 1, 0, 0, ones48, '0, ones48, '0);
        // random operations
        for (int k = 0; k < 30 && D < MAXC - 2500; k++) begin
            P = D + $urandom_range(1, 3);
            for (int j = 0; j < 15; j++) begin
                r = $urandom_range(0, 39);
                g_w[j] = (r == 0) ? 0 : ((r < 4) ? $urandom_range(5, 20) : $urandom_range(1, 3));
                g_d[j] = rnd48();
            end
            plan_op(P, $urandom_range(0, 15),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 4),
                    D, w2);
        end
        end_c = D + 5;

        apply(0);
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk); #1;
            apply(c);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 500 && !small_fin; i++) @(posedge clk);
        if (!small_fin) begin
            tests++; fails++;
            $display("FAIL small_timeout: small-instance sequence did not finish in budget");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Small instance: sa_rdy always high, so each read lands in its first WAIT
    // cycle; with s=0 read k is sampled at relative cycle 3+4k.
    task automatic run_small(input logic [2:0] nr, input int n);
        logic [47:0] words[40];
        logic [47:0] dd, ds, ed, es;
        int pulses, dcyc, ones;
        pulses = 0; dcyc = -1; dd = '0; ds = '0;
        for (int r = 0; r < 40; r++) begin
            start_s = (r == 0); num_reads_s = nr; setup_s = 8'd0;
            sa_do_s = rnd48(); words[r] = sa_do_s;
            @(negedge clk);
            if (sa_clk_s) pulses++;
            if (done_s) begin dcyc = r; dd = rd_data_s; ds = rd_stable_s; end
            @(posedge clk); #1;
        end
        for (int b = 0; b < 48; b++) begin
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(words[3 + 4 * k][b]);
            ed[b] = (2 * ones > n);
            es[b] = (ones == 0) || (ones == n);
        end
        chk("small_pulses",    48'(pulses), 48'(n));
        chk("small_done_cyc",  48'(dcyc),   48'(4 * n));
        chk("small_rd_data",   dd, ed);
        chk("small_rd_stable", ds, es);
    endtask

    initial begin
        rst_s = 1'b1; start_s = 1'b0; sa_rdy_s = 1'b1; num_reads_s = '0;
        setup_s = '0; sa_do_s = '0;
        repeat (3) @(posedge clk);
        #1 rst_s = 1'b0;
        run_small(3'd7, 5);
        run_small(3'd0, 1);
        small_fin = 1'b1;
    end
endmodule

// File: doc/rram_sa_vote.md
# rram_sa_vote

Parametrised multi-read sense-amp sequencer for the RRAM analog interface. On a start pulse it runs 1..NUM_READS_MAX read cycles on the sense amplifier, counts the ones per bit of `sa_do`, and returns a strict-majority word together with a per-bit stability mask. It sits between the read/verify FSM and the analog block's `sa_en`/`sa_clk`/`sa_do`/`sa_rdy` pins. It generalises the single-shot `sa_do` capture with configurable read count, setup time, timeout and voting.

## Interface
- `WORD_SIZE`, 48, width of `sa_do` and of the result words
- `NUM_READS_MAX`, 15, maximum reads per operation; CW = clog2(NUM_READS_MAX+1)
- `TIMEOUT_CYCLES`, 255, maximum WAIT cycles allowed per read before abort
- `mclk`  in  1  single clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `num_reads`  in  CW  read count; 0 is treated as 1; values above NUM_READS_MAX are clamped to it
- `setup_cycles`  in  8  extra cycles of `sa_en` high before each `sa_clk` pulse
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle completion pulse
- `timeout`  out  1  high together with `done` when the operation aborted
- `sa_en`  out  1  sense-amp enable
- `sa_clk`  out  1  sense-amp strobe
- `sa_do`  in  WORD_SIZE  sense-amp data, valid while `sa_rdy` is high
- `sa_rdy`  in  1  sense-amp data-valid flag
- `rd_data`  out  WORD_SIZE  majority result
- `rd_stable`  out  WORD_SIZE  bit i is 1 when all reads agreed on bit i

## Operation
- All outputs are registered. On reset every output is 0, the state is IDLE, and all counters and latched config are cleared. A reset mid-operation aborts immediately and produces no `done`.
- IDLE: `sa_en`=0 and `sa_clk`=0.
  - On `start`, latch n = clamp(max(`num_reads`,1)) and s = `setup_cycles`.
  - Clear the read index, the WAIT counter and the per-bit one-counters (WORD_SIZE × CW bits).
  - Move to SETUP.
- SETUP: `sa_en`=1 for s+1 cycles, then move to CLK.
- CLK: `sa_en`=1 and `sa_clk`=1 for exactly 1 cycle, then move to WAIT.
- WAIT: `sa_en`=1 and `sa_clk`=0. `sa_rdy` is sampled every cycle.
  - When `sa_rdy`=1, add `sa_do[i]` to ones[i] and increment the read index.
    - If the index now equals n, move to DONE.
    - Otherwise move to REARM.
  - If TIMEOUT_CYCLES consecutive WAIT cycles pass with `sa_rdy`=0, move to DONE with the abort flag set.
  - `sa_rdy` in the final (TIMEOUT_CYCLES-th) cycle is still accepted.
- REARM: `sa_en`=0 for 1 cycle, then move to SETUP.
- DONE: `sa_en`=0, `done`=1 for 1 cycle, then move to IDLE.
  - Normal completion: `rd_data[i]` = (2·ones[i] > n), so ties give 0. `rd_stable[i]` = (ones[i]==0) || (ones[i]==n).
  - Abort: `rd_data`=0, `rd_stable`=0, `timeout`=1.
  - `rd_data` and `rd_stable` hold their values until the next DONE or reset.
- `start` while `busy` is ignored. `sa_rdy` outside WAIT is ignored.
- Counters cannot overflow because ones[i] ≤ n ≤ NUM_READS_MAX.

## Timing
- Cycle 0 is the edge where `start` is sampled. `busy` and `sa_en` are high from cycle 1.
- Per read: SETUP (s+1) + CLK 1 + WAIT w, where w ≥ 1 is the cycle index in which `sa_rdy` is seen.
- REARM adds 1 cycle between consecutive reads.
- When `sa_rdy` is returned in the first WAIT cycle, `done` is high in cycle n·(s+3) + (n−1) + 1.
- Result outputs update in the same cycle as `done`. `busy` falls in the cycle after `done`.
- A new `start` is accepted in the first IDLE cycle, i.e. the cycle after `done`.
- Abort: `done` and `timeout` rise in the cycle after the TIMEOUT_CYCLES-th empty WAIT cycle.

## Test plan
- Single read, vote trivial:
  - Stimulus: n=1, s=0, `sa_rdy` in the first WAIT cycle with `sa_do`=0xA5A5_0000_FFFF.
  - Required: `rd_data` equals that value and `rd_stable` is all ones; one `sa_clk` pulse; `done` at cycle 4.
- Majority vote:
  - Stimulus: n=3, s=2, reads 0x...F0, 0x...CC, 0x...AA.
  - Required: `rd_data` low byte 0xE8 and `rd_stable` low byte 0x81; `done` at cycle 18; `sa_en` low in exactly 2 REARM cycles.
- Tie rule:
  - Stimulus: n=2, reads 0x1 then 0x0.
  - Required: bit0 `rd_data`=0 and `rd_stable`=0.
- Timeout:
  - Stimulus: n=2, `sa_rdy` held 0.
  - Required: `done`=`timeout`=1 exactly TIMEOUT_CYCLES+1 cycles after WAIT entry; outputs 0; `sa_en`=0 in the DONE cycle.
  - Also: with `sa_rdy` rising in WAIT cycle 255, the read is accepted and no timeout occurs.
- Clamp and zero count:
  - Stimulus: `num_reads`=0 gives exactly 1 `sa_clk` pulse; set NUM_READS_MAX=5 and `num_reads`=7.
  - Required: exactly 5 pulses.
- Reset and restart:
  - Stimulus: assert `rst` in WAIT of read 2; re-issue `start` while `busy`.
  - Required: all outputs 0 the next cycle with no `done`; the restart is ignored; a fresh `start` after `done` runs normally.
